mod_addsub_vec: RTL and testbench

MOD_ADDSUB_VEC -- requirements
Module: mod_addsub_vec

---
 rtl/poly_arith_pkg.sv | 27 ++
 rtl/mod_addsub_lane.sv | 29 ++
 rtl/mod_addsub_vec.sv | 84 ++++++++
 tb/tb_mod_addsub_vec.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/poly_arith_pkg.sv
// Shared coefficient types and constants for modular polynomial arithmetic
// over Z_Q with Q = 3329.
package poly_arith_pkg;

    localparam int unsigned COEFF_W = 12;
    localparam int unsigned RAW_W   = COEFF_W + 1;

    typedef logic [COEFF_W-1:0] coeff_t;
    typedef logic [RAW_W-1:0]   raw_t;

    localparam coeff_t Q = 12'd3329;

    // Add results are read as unsigned (up to 2*Q-2) while subtract results
    // are read as two's complement, so 13 bits cover both.
    function automatic raw_t raw_op(input coeff_t a, input coeff_t b, input logic sub);
        raw_t a_ext;
        raw_t b_ext;
        a_ext = {1'b0, a};
        b_ext = {1'b0, b};
        return sub ? (a_ext - b_ext) : (a_ext + b_ext);
    endfunction

    function automatic logic out_of_range(input coeff_t a);
        return a >= Q;
    endfunction

endpackage

// File: rtl/mod_addsub_lane.sv
// Single-lane conditional correction that folds a raw add/subtract result
// back into [0, Q-1].
module mod_addsub_lane
    import poly_arith_pkg::*;
(
    input  raw_t   raw,
    input  logic   sub,
    output coeff_t res
);

    raw_t q_ext;
    raw_t corr;

    assign q_ext = {1'b0, Q};

    always_comb begin
        corr = raw;
        if (sub) begin
            if (raw[RAW_W-1]) begin
                corr = raw + q_ext;
            end
        end else if (raw >= q_ext) begin
            corr = raw - q_ext;
        end
    end

    assign res = corr[COEFF_W-1:0];

endmodule

// File: rtl/mod_addsub_vec.sv
// LANES-wide modular add/subtract with a two-stage valid/ready pipeline:
// S1 holds raw sums/differences, S2 holds the reduced results.
module mod_addsub_vec
    import poly_arith_pkg::*;
#(
    parameter int LANES   = 4,
    parameter bit SAT_ERR = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  coeff_t [LANES-1:0]   op1_i,
    input  coeff_t [LANES-1:0]   op2_i,
    input  logic                 mode_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output coeff_t [LANES-1:0]   result_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 err_o
);

    logic               en1;
    logic               en2;
    logic               s1_valid_reg;
    logic               s1_mode_reg;
    raw_t [LANES-1:0]   s1_raw_reg;
    raw_t [LANES-1:0]   raw_next;
    coeff_t [LANES-1:0] corr_next;
    coeff_t [LANES-1:0] result_reg;
    logic               valid_reg;
    logic               err_reg;
    logic               err_next;
    logic [LANES-1:0]   oor_lane;

    // Invalid stages always accept, so bubbles collapse.
    assign en2     = !valid_reg || ready_i;
    assign en1     = !s1_valid_reg || en2;
    assign ready_o = en1;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign raw_next[gi] = raw_op(op1_i[gi], op2_i[gi], mode_i);
            assign oor_lane[gi] = out_of_range(op1_i[gi]) || out_of_range(op2_i[gi]);

            mod_addsub_lane u_lane (
                .raw (s1_raw_reg[gi]),
                .sub (s1_mode_reg),
                .res (corr_next[gi])
            );
        end
    endgenerate

    // Sticky mode keeps the flag until reset; pulse mode reflects only the
    // beat accepted on the previous edge.
    assign err_next = (valid_i && en1 && (|oor_lane)) || (SAT_ERR && err_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_mode_reg  <= 1'b0;
            s1_raw_reg   <= '0;
            valid_reg    <= 1'b0;
            result_reg   <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (en1) begin
                s1_valid_reg <= valid_i;
                s1_mode_reg  <= mode_i;
                s1_raw_reg   <= raw_next;
            end
            if (en2) begin
                valid_reg  <= s1_valid_reg;
                result_reg <= corr_next;
            end
            err_reg <= err_next;
        end
    end

    assign result_o = result_reg;
    assign valid_o  = valid_reg;
    assign err_o    = err_reg;

endmodule

// File: tb/tb_mod_addsub_vec.sv
// Directed-vector and streaming bench for mod_addsub_vec (LANES = 4), with a
// second instance in pulse-error mode sharing the same stimulus.
module tb_mod_addsub_vec;
    import poly_arith_pkg::*;

    localparam int QM = 3329;

    logic           clk;
    logic           rst;
    coeff_t [3:0]   op1_i;
    coeff_t [3:0]   op2_i;
    logic           mode_i;
    logic           valid_i;
    logic           ready_i;
    logic           ready_o;
    coeff_t [3:0]   result_o;
    logic           valid_o;
    logic           err_o;
    logic           ready_p;
    coeff_t [3:0]   result_p;
    logic           valid_p;
    logic           err_p;

    mod_addsub_vec #(.LANES(4), .SAT_ERR(1'b1)) dut (
        .clk(clk), .rst(rst), .op1_i(op1_i), .op2_i(op2_i), .mode_i(mode_i),
        .valid_i(valid_i), .ready_o(ready_o), .result_o(result_o),
        .valid_o(valid_o), .ready_i(ready_i), .err_o(err_o)
    );

    mod_addsub_vec #(.LANES(4), .SAT_ERR(1'b0)) dut_p (
        .clk(clk), .rst(rst), .op1_i(op1_i), .op2_i(op2_i), .mode_i(mode_i),
        .valid_i(valid_i), .ready_o(ready_p), .result_o(result_p),
        .valid_o(valid_p), .ready_i(ready_i), .err_o(err_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int op1[4];
        int op2[4];
        bit mode;
        int exp[4];
    } vec_t;

    vec_t         tbl[6];
    int           n_vec = 0;
    int           n_bad = 0;
    int           out_cnt = 0;
    bit           sb_en = 1'b0;
    logic [47:0]  sbq[$];
    logic [47:0]  mon_exp;

    function automatic int modq(input int a, input int b, input bit m);
        int r;
        r = m ? (a - b) : (a + b);
        r = r % QM;
        if (r < 0) r += QM;
        return r;
    endfunction

    task automatic chk(input string name, input logic [47:0] got, input logic [47:0] req);
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    // Scoreboard: expected values are pushed on input transfer, checked on output transfer.
    always @(negedge clk) begin
        if (!rst && sb_en) begin
            if (valid_o && ready_i) begin
                out_cnt++;
                n_vec++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL stream_extra: got %h required no beat", result_o);
                end else begin
                    mon_exp = sbq.pop_front();
                    if (result_o !== mon_exp) begin
                        n_bad++;
                        $display("FAIL stream_beat%0d: got %h required %h", out_cnt, result_o, mon_exp);
                    end
                end
            end
            if (valid_i && ready_o) begin
                for (int k = 0; k < 4; k++)
                    mon_exp[12*k +: 12] = 12'(modq(int'(op1_i[k]), int'(op2_i[k]), mode_i));
                sbq.push_back(mon_exp);
            end
        end
    end

    task automatic run_stream(input int n, input bit rnd);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        out_cnt = 0;
        sb_en = 1'b1;
        while ((idx < n || sbq.size() != 0) && cyc < 20000) begin
            ready_i = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 3 && cyc <= 7);
            valid_i = (idx < n) && (!rnd || $urandom_range(0, 4) != 0);
            mode_i  = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                op1_i[k] = 12'($urandom_range(0, QM - 1));
                op2_i[k] = 12'($urandom_range(0, QM - 1));
            end
            @(negedge clk);
            if (!rnd && cyc >= 3 && cyc <= 8)
                chk($sformatf("bp_ready_cyc%0d", cyc), 48'(ready_o), 48'(cyc == 8));
            if (valid_i && ready_o) idx++;
            @(posedge clk);
            #1;
            cyc++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        sb_en = 1'b0;
        chk(rnd ? "rand_timeout" : "bp_timeout", 48'(cyc >= 20000), 48'(0));
        chk(rnd ? "rand_out_count" : "bp_out_count", 48'(out_cnt), 48'(n));
    endtask

    function automatic logic [47:0] pack4(input int e[4]);
        logic [47:0] p;
        for (int k = 0; k < 4; k++) p[12*k +: 12] = 12'(e[k]);
        return p;
    endfunction

    initial begin
        tbl[0].op1 = '{50, 20, 0, 0};        tbl[0].op2 = '{20, 50, 1, 3328};
        tbl[0].mode = 1'b1;                  tbl[0].exp = '{30, 3299, 3328, 1};
        tbl[1].op1 = '{3328, 1664, 3328, 0}; tbl[1].op2 = '{1, 1665, 3328, 0};
        tbl[1].mode = 1'b0;                  tbl[1].exp = '{0, 0, 3327, 0};
        tbl[2].op1 = '{100, 3000, 3000, 1};  tbl[2].op2 = '{200, 329, 328, 1};
        tbl[2].mode = 1'b0;                  tbl[2].exp = '{300, 0, 3328, 2};
        tbl[3].op1 = '{5, 1, 3328, 0};       tbl[3].op2 = '{5, 2, 0, 0};
        tbl[3].mode = 1'b1;                  tbl[3].exp = '{0, 3328, 3328, 0};
        tbl[4].op1 = '{2000, 1000, 3328, 3327}; tbl[4].op2 = '{1000, 2000, 3327, 3328};
        tbl[4].mode = 1'b1;                  tbl[4].exp = '{1000, 2329, 1, 3328};
        tbl[5].op1 = '{1664, 0, 2, 3000};    tbl[5].op2 = '{1664, 3328, 3327, 1000};
        tbl[5].mode = 1'b0;                  tbl[5].exp = '{3328, 3328, 0, 671};

        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; mode_i = 1'b0;
        op1_i = '0; op2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid_o", 48'(valid_o), 48'(0));
        chk("reset_err_o", 48'(err_o), 48'(0));
        chk("reset_result_o", result_o, 48'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready_o", 48'(ready_o), 48'(1));

        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                op1_i[k] = 12'(tbl[i].op1[k]);
                op2_i[k] = 12'(tbl[i].op2[k]);
            end
            mode_i = tbl[i].mode;
            valid_i = 1'b1;
            @(posedge clk);
            #1;
            valid_i = 1'b0;
            chk($sformatf("vec%0d_lat1_valid", i), 48'(valid_o), 48'(0));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_lat2_valid", i), 48'(valid_o), 48'(1));
            chk($sformatf("vec%0d_result", i), result_o, pack4(tbl[i].exp));
        end
        repeat (3) @(posedge clk);
        #1;

        run_stream(6, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        run_stream(1000, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Reset with two beats in flight.
        valid_i = 1'b1; op1_i = '{12'd1, 12'd2, 12'd3, 12'd4}; op2_i = '0; mode_i = 1'b0;
        @(posedge clk);
        #1;
        op1_i = '{12'd5, 12'd6, 12'd7, 12'd8};
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        chk("flight_valid_before_rst", 48'(valid_o), 48'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("flight_valid_async_clear", 48'(valid_o), 48'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("flight_ready_after_rst", 48'(ready_o), 48'(1));
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("flight_no_stale_cyc%0d", c), 48'(valid_o), 48'(0));
        end

        // Out-of-range operand detection.
        chk("err_idle_sticky", 48'(err_o), 48'(0));
        op1_i = '0; op2_i = '0; op1_i[2] = 12'd3329; mode_i = 1'b0; valid_i = 1'b1;
        @(negedge clk);
        chk("err_before_edge", 48'(err_o), 48'(0));
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        chk("err_set_sticky", 48'(err_o), 48'(1));
        chk("err_set_pulse", 48'(err_p), 48'(1));
        @(posedge clk);
        #1;
        chk("err_hold_sticky", 48'(err_o), 48'(1));
        chk("err_end_pulse", 48'(err_p), 48'(0));
        op1_i = '{12'd3328, 12'd3328, 12'd3328, 12'd3328}; op2_i = op1_i; valid_i = 1'b1;
        @(posedge clk);
        #1;
        op2_i[0] = 12'd4095;
        chk("err_inrange_pulse", 48'(err_p), 48'(0));
        chk("err_inrange_sticky", 48'(err_o), 48'(1));
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        chk("err_op2_pulse", 48'(err_p), 48'(1));
        @(posedge clk);
        #1;
        chk("err_op2_pulse_end", 48'(err_p), 48'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
